// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI state array: line states, commands, snoop results,
// bus operations, controller states and the registered response payload.
package mesi_pkg;

  typedef enum logic [1:0] {
    ST_M = 2'd0,
    ST_E = 2'd1,
    ST_S = 2'd2,
    ST_I = 2'd3
  } mesi_state_e;

  typedef enum logic [3:0] {
    CMD_L1_READ   = 4'd0,
    CMD_L1_WRITE  = 4'd1,
    CMD_L1_IREAD  = 4'd2,
    CMD_SNP_INV   = 4'd3,
    CMD_SNP_READ  = 4'd4,
    CMD_SNP_WRITE = 4'd5,
    CMD_SNP_RFO   = 4'd6,
    CMD_CLEAR     = 4'd8,
    CMD_PRINT     = 4'd9
  } cmd_e;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snoop_e;

  typedef enum logic [1:0] {
    BUS_NONE      = 2'd0,
    BUS_READ      = 2'd1,
    BUS_RFO       = 2'd2,
    BUS_WRITEBACK = 2'd3
  } bus_op_e;

  typedef enum logic {
    FSM_IDLE  = 1'b0,
    FSM_CLEAR = 1'b1
  } fsm_e;

  typedef struct packed {
    mesi_state_e prev;
    mesi_state_e next;
    bus_op_e     bus;
    snoop_e      snoop;
    logic        err;
  } rsp_t;

  // L1-side accesses are the only ones that feed the hit/miss statistics
  function automatic logic is_l1_cmd(input logic [3:0] cmd);
    return cmd <= 4'd2;
  endfunction

endpackage

// File: rtl/mesi_next_state.sv
// Combinational MESI transition function: given a line's current state, a command and
// the other caches' snoop response, produce the new state, bus op and our snoop result.
module mesi_next_state
  import mesi_pkg::*;
(
  input  mesi_state_e cur_state,
  input  logic [3:0]  cmd,
  input  logic [1:0]  snoop_resp,
  output mesi_state_e next_state,
  output bus_op_e     bus_op,
  output snoop_e      snoop_out,
  output logic        illegal
);

  always_comb begin
    next_state = cur_state;
    bus_op     = BUS_NONE;
    snoop_out  = SNP_NOHIT;
    illegal    = 1'b0;
    case (cmd)
      CMD_L1_READ, CMD_L1_IREAD: begin
        if (cur_state == ST_I) begin
          bus_op     = BUS_READ;
          next_state = (snoop_resp == SNP_NOHIT) ? ST_E : ST_S;
        end
      end
      CMD_L1_WRITE: begin
        next_state = ST_M;
        if (cur_state == ST_S || cur_state == ST_I) bus_op = BUS_RFO;
      end
      CMD_SNP_INV: begin
        next_state = ST_I;
        if (cur_state == ST_S) snoop_out = SNP_HIT;
      end
      CMD_SNP_READ, CMD_SNP_RFO: begin
        // read leaves a shared copy, RFO gives the line away entirely
        case (cur_state)
          ST_M: begin
            snoop_out  = SNP_HITM;
            bus_op     = BUS_WRITEBACK;
            next_state = (cmd == CMD_SNP_READ) ? ST_S : ST_I;
          end
          ST_E, ST_S: begin
            snoop_out  = SNP_HIT;
            next_state = (cmd == CMD_SNP_READ) ? ST_S : ST_I;
          end
          default: next_state = ST_I;
        endcase
      end
      CMD_SNP_WRITE, CMD_CLEAR, CMD_PRINT: next_state = cur_state;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mesi_state_array.sv
// Per-(set, way) MESI state store with a one-request-per-cycle controller, a multi-cycle
// clear sweep, a registered response and saturating hit/miss statistics.
module mesi_state_array
  import mesi_pkg::*;
#(
  parameter int unsigned SETS  = 16,
  parameter int unsigned WAYS  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3:0]              req_cmd,
  input  logic [$clog2(SETS)-1:0] req_set,
  input  logic [$clog2(WAYS)-1:0] req_way,
  input  logic [1:0]              req_snoop_resp,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_prev_state,
  output logic [1:0]              rsp_next_state,
  output logic [1:0]              rsp_bus_op,
  output logic [1:0]              rsp_snoop_out,
  output logic                    rsp_err,
  output logic [CNT_W-1:0]        stat_hits,
  output logic [CNT_W-1:0]        stat_misses
);

  localparam int unsigned SET_W = $clog2(SETS);

  mesi_state_e      mem [SETS][WAYS];
  fsm_e             fsm;
  logic [SET_W-1:0] sweep;
  rsp_t             rsp_q;

  logic        way_ok_c;
  logic        err_c;
  logic        accept_c;
  mesi_state_e cur_c;
  mesi_state_e ns_c;
  bus_op_e     bus_c;
  snoop_e      snoop_c;
  logic        illegal_c;

  // out-of-range ways read as I so the transition logic never indexes past the array
  assign way_ok_c = 32'(req_way) < WAYS;
  assign cur_c    = way_ok_c ? mem[req_set][req_way] : ST_I;
  assign err_c    = illegal_c || (!way_ok_c && req_cmd != CMD_CLEAR);
  assign accept_c = req_valid && req_ready;

  mesi_next_state u_next (
    .cur_state  (cur_c),
    .cmd        (req_cmd),
    .snoop_resp (req_snoop_resp),
    .next_state (ns_c),
    .bus_op     (bus_c),
    .snoop_out  (snoop_c),
    .illegal    (illegal_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          mem[s][w] <= ST_I;
      fsm         <= FSM_IDLE;
      req_ready   <= 1'b1;
      sweep       <= '0;
      rsp_valid   <= 1'b0;
      rsp_q       <= '{prev: ST_I, next: ST_I, bus: BUS_NONE, snoop: SNP_NOHIT, err: 1'b0};
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (fsm == FSM_IDLE) begin
        if (accept_c && req_cmd == CMD_CLEAR) begin
          fsm         <= FSM_CLEAR;
          req_ready   <= 1'b0;
          sweep       <= '0;
          stat_hits   <= '0;
          stat_misses <= '0;
        end else if (accept_c) begin
          rsp_valid   <= 1'b1;
          rsp_q.prev  <= cur_c;
          rsp_q.next  <= err_c ? cur_c : ns_c;
          rsp_q.bus   <= err_c ? BUS_NONE : bus_c;
          rsp_q.snoop <= err_c ? SNP_NOHIT : snoop_c;
          rsp_q.err   <= err_c;
          if (!err_c) mem[req_set][req_way] <= ns_c;
          // statistics saturate instead of wrapping
          if (is_l1_cmd(req_cmd) && !err_c) begin
            if (cur_c == ST_I) begin
              if (stat_misses != '1) stat_misses <= stat_misses + CNT_W'(1);
            end else begin
              if (stat_hits != '1) stat_hits <= stat_hits + CNT_W'(1);
            end
          end
        end
      end else begin
        for (int unsigned w = 0; w < WAYS; w++)
          mem[sweep][w] <= ST_I;
        if (32'(sweep) == SETS - 1) begin
          fsm       <= FSM_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_q     <= '{prev: ST_I, next: ST_I, bus: BUS_NONE, snoop: SNP_NOHIT, err: 1'b0};
        end else begin
          sweep <= sweep + SET_W'(1);
        end
      end
    end
  end

  assign rsp_prev_state = rsp_q.prev;
  assign rsp_next_state = rsp_q.next;
  assign rsp_bus_op     = rsp_q.bus;
  assign rsp_snoop_out  = rsp_q.snoop;
  assign rsp_err        = rsp_q.err;

endmodule

// File: tb/tb_mesi_state_array.sv
// Self-checking bench for mesi_state_array: directed vector table, clear/reset corner
// sequences and a randomized run against a behavioural MESI model.
module tb_mesi_state_array;

  localparam int unsigned SETS  = 8;
  localparam int unsigned WAYS  = 6;
  localparam int unsigned CNT_W = 2;
  localparam int SW  = $clog2(SETS);
  localparam int WW  = $clog2(WAYS);
  localparam int SAT = 3;

  // line states, bus ops and snoop results as plain numbers
  localparam int SM = 0, SE = 1, SS = 2, SI = 3;
  localparam int B_NONE = 0, B_READ = 1, B_RFO = 2, B_WB = 3;
  localparam int R_NOHIT = 0, R_HIT = 1, R_HITM = 2;

  logic clk = 1'b0;
  logic rst;
  logic req_valid;
  logic req_ready;
  logic [3:0] req_cmd;
  logic [SW-1:0] req_set;
  logic [WW-1:0] req_way;
  logic [1:0] req_snoop_resp;
  logic rsp_valid;
  logic [1:0] rsp_prev_state, rsp_next_state, rsp_bus_op, rsp_snoop_out;
  logic rsp_err;
  logic [CNT_W-1:0] stat_hits, stat_misses;

  always #5 clk = ~clk;

  mesi_state_array #(.SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cmd        (req_cmd),
    .req_set        (req_set),
    .req_way        (req_way),
    .req_snoop_resp (req_snoop_resp),
    .rsp_valid      (rsp_valid),
    .rsp_prev_state (rsp_prev_state),
    .rsp_next_state (rsp_next_state),
    .rsp_bus_op     (rsp_bus_op),
    .rsp_snoop_out  (rsp_snoop_out),
    .rsp_err        (rsp_err),
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
  );

  typedef struct {
    int prev, nxt, bus, so, err, full, hits, miss;
  } exp_t;

  typedef struct {
    int cmd, set, way, snp;
    exp_t e;
  } vec_t;

  int   nchk = 0;
  int   nerr = 0;
  int   mdl [SETS][WAYS];
  int   mh, mm;
  vec_t vt [25];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        mdl[s][w] = SI;
    mh = 0;
    mm = 0;
  endtask

  // behavioural MESI rules; returns the expected response and advances the model
  task automatic model_step(input int cmd, input int s, input int w, input int snp, output exp_t e);
    int cur, nxt;
    bit legal;
    e = '{default: 0};
    e.full = 1;
    legal = (cmd <= 6) || (cmd == 9);
    if (w >= WAYS) begin
      e.err = 1; e.full = 0; e.hits = mh; e.miss = mm;
      return;
    end
    cur = mdl[s][w];
    nxt = cur;
    if (!legal) begin
      e.err = 1;
    end else if (cmd == 0 || cmd == 2) begin
      if (cur == SI) begin
        e.bus = B_READ;
        nxt = (snp == R_NOHIT) ? SE : SS;
      end
    end else if (cmd == 1) begin
      nxt = SM;
      if (cur == SS || cur == SI) e.bus = B_RFO;
    end else if (cmd == 3) begin
      e.so = (cur == SS) ? R_HIT : R_NOHIT;
      nxt = SI;
    end else if (cmd == 4 || cmd == 6) begin
      if (cur != SI) begin
        e.so = (cur == SM) ? R_HITM : R_HIT;
        if (cur == SM) e.bus = B_WB;
        nxt = (cmd == 4) ? SS : SI;
      end
    end
    if (legal && cmd <= 2) begin
      if (cur == SI) mm = (mm < SAT) ? mm + 1 : SAT;
      else           mh = (mh < SAT) ? mh + 1 : SAT;
    end
    mdl[s][w] = nxt;
    e.prev = cur; e.nxt = nxt; e.hits = mh; e.miss = mm;
  endtask

  task automatic drive(input int cmd, input int s, input int w, input int snp);
    req_valid      = 1'b1;
    req_cmd        = 4'(cmd);
    req_set        = SW'(s);
    req_way        = WW'(w);
    req_snoop_resp = 2'(snp);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_rsp_valid", rsp_valid, 0);
  endtask

  task automatic check_rsp(input string tag, input exp_t e);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_err"}, rsp_err, e.err);
    if (e.full != 0) begin
      chk({tag, "_prev"}, rsp_prev_state, e.prev);
      chk({tag, "_next"}, rsp_next_state, e.nxt);
      chk({tag, "_bus"}, rsp_bus_op, e.bus);
      chk({tag, "_snoop"}, rsp_snoop_out, e.so);
    end
    chk({tag, "_hits"}, stat_hits, e.hits);
    chk({tag, "_misses"}, stat_misses, e.miss);
  endtask

  task automatic model_req(input string tag, input int cmd, input int s, input int w, input int snp);
    exp_t e;
    model_step(cmd, s, w, snp, e);
    drive(cmd, s, w, snp);
    check_rsp(tag, e);
  endtask

  task automatic print_all(input string tag);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        model_req(tag, 9, s, w, 0);
    idle();
  endtask

  task automatic do_clear();
    int  low, pulses;
    bit  done;
    drive(8, $urandom_range(0, SETS - 1), $urandom_range(0, (1 << WW) - 1), 0);
    req_valid = 1'b0;
    low = 0; pulses = 0; done = 1'b0;
    for (int k = 0; k < SETS + 8 && !done; k++) begin
      if (rsp_valid) pulses++;
      if (req_ready) done = 1'b1;
      else begin
        low++;
        @(posedge clk); #1;
      end
    end
    chk("clear_finished", done, 1);
    chk("clear_ready_low_cycles", low, SETS);
    chk("clear_rsp_pulses", pulses, 1);
    chk("clear_err", rsp_err, 0);
    chk("clear_hits", stat_hits, 0);
    chk("clear_misses", stat_misses, 0);
    @(posedge clk); #1;
    chk("clear_single_pulse", rsp_valid, 0);
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   cnt;
    // cmd, set, way, snp, {prev, next, bus, snoop, err, full, hits, misses}
    vt[0]  = '{0, 3, 2, 0, '{SI, SE, B_READ, R_NOHIT, 0, 1, 0, 1}};
    vt[1]  = '{1, 3, 2, 0, '{SE, SM, B_NONE, R_NOHIT, 0, 1, 1, 1}};
    vt[2]  = '{4, 3, 2, 0, '{SM, SS, B_WB,   R_HITM,  0, 1, 1, 1}};
    vt[3]  = '{0, 3, 2, 0, '{SS, SS, B_NONE, R_NOHIT, 0, 1, 2, 1}};
    vt[4]  = '{2, 1, 0, 1, '{SI, SS, B_READ, R_NOHIT, 0, 1, 2, 2}};
    vt[5]  = '{1, 1, 0, 0, '{SS, SM, B_RFO,  R_NOHIT, 0, 1, 3, 2}};
    vt[6]  = '{6, 1, 0, 0, '{SM, SI, B_WB,   R_HITM,  0, 1, 3, 2}};
    vt[7]  = '{3, 3, 2, 0, '{SS, SI, B_NONE, R_HIT,   0, 1, 3, 2}};
    vt[8]  = '{7, 3, 2, 0, '{SI, SI, B_NONE, R_NOHIT, 1, 1, 3, 2}};
    vt[9]  = '{0, 0, 6, 0, '{0, 0, 0, 0, 1, 0, 3, 2}};
    vt[10] = '{5, 3, 2, 0, '{SI, SI, B_NONE, R_NOHIT, 0, 1, 3, 2}};
    vt[11] = '{1, 5, 5, 0, '{SI, SM, B_RFO,  R_NOHIT, 0, 1, 3, 3}};
    vt[12] = '{0, 5, 5, 0, '{SM, SM, B_NONE, R_NOHIT, 0, 1, 3, 3}};
    vt[13] = '{15, 5, 5, 0, '{SM, SM, B_NONE, R_NOHIT, 1, 1, 3, 3}};
    vt[14] = '{9, 5, 5, 0, '{SM, SM, B_NONE, R_NOHIT, 0, 1, 3, 3}};
    vt[15] = '{4, 5, 5, 0, '{SM, SS, B_WB,   R_HITM,  0, 1, 3, 3}};
    vt[16] = '{6, 5, 5, 0, '{SS, SI, B_NONE, R_HIT,   0, 1, 3, 3}};
    vt[17] = '{0, 2, 1, 0, '{SI, SE, B_READ, R_NOHIT, 0, 1, 3, 3}};
    vt[18] = '{4, 2, 1, 0, '{SE, SS, B_NONE, R_HIT,   0, 1, 3, 3}};
    vt[19] = '{2, 4, 3, 2, '{SI, SS, B_READ, R_NOHIT, 0, 1, 3, 3}};
    vt[20] = '{6, 4, 3, 0, '{SS, SI, B_NONE, R_HIT,   0, 1, 3, 3}};
    vt[21] = '{1, 0, 7, 0, '{0, 0, 0, 0, 1, 0, 3, 3}};
    vt[22] = '{0, 6, 0, 0, '{SI, SE, B_READ, R_NOHIT, 0, 1, 3, 3}};
    vt[23] = '{3, 6, 0, 0, '{SE, SI, B_NONE, R_NOHIT, 0, 1, 3, 3}};
    vt[24] = '{6, 6, 0, 0, '{SI, SI, B_NONE, R_NOHIT, 0, 1, 3, 3}};

    rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_set = '0; req_way = '0; req_snoop_resp = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", req_ready, 1);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_prev", rsp_prev_state, SI);
    chk("reset_next", rsp_next_state, SI);
    chk("reset_bus", rsp_bus_op, 0);
    chk("reset_snoop", rsp_snoop_out, 0);
    chk("reset_err", rsp_err, 0);
    chk("reset_hits", stat_hits, 0);
    chk("reset_misses", stat_misses, 0);
    model_reset();

    // directed vectors, applied back to back
    for (int i = 0; i < 25; i++) begin
      model_step(vt[i].cmd, vt[i].set, vt[i].way, vt[i].snp, e);
      drive(vt[i].cmd, vt[i].set, vt[i].way, vt[i].snp);
      check_rsp($sformatf("vec%0d", i), vt[i].e);
    end
    idle();

    // lines at both ends of the set range, then a full clear sweep
    model_req("fill_lo", 1, 0, 0, 0);
    model_req("fill_hi", 0, SETS - 1, WAYS - 1, 0);
    idle();
    do_clear();
    print_all("post_clear");

    // randomized traffic against the model
    for (int it = 0; it < 600; it++) begin
      int r, cmd;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_clear();
      end else if (r < 8) begin
        idle();
      end else begin
        if (r < 14) cmd = ($urandom_range(0, 6) == 0) ? 7 : $urandom_range(10, 15);
        else if (r < 55) cmd = $urandom_range(0, 2);
        else begin
          cmd = $urandom_range(3, 7);
          if (cmd == 7) cmd = 9;
        end
        model_req($sformatf("rnd%0d", it), cmd, $urandom_range(0, SETS - 1),
                  $urandom_range(0, WAYS), $urandom_range(0, 2));
      end
    end
    idle();

    // reset in the middle of a clear sweep
    model_req("pre_abort_hi", 1, SETS - 1, 0, 0);
    model_req("pre_abort_lo", 0, 0, 1, 0);
    idle();
    drive(8, 0, 0, 0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("abort_ready", req_ready, 1);
    chk("abort_valid", rsp_valid, 0);
    cnt = 0;
    for (int k = 0; k < 2 * SETS; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) cnt++;
    end
    chk("abort_no_rsp", cnt, 0);
    print_all("post_abort");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
